// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: IDLE -> ACCESS (ACCESS_CYCLES) -> DONE.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (A wins).
module sram_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 128,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              done_a,
   output logic              done_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              sram_read,
   output logic              sram_write,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              gnt_b_q, gnt_b_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
   logic              pick_b;
   logic              in_access;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // Set when B was served last; resets high so A wins the first contest.
   logic              last_b_q, last_b_d;

   assign pick_b = req_b & (~req_a | ~last_b_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_d;
      end
   end
`else
   assign pick_b = req_b & ~req_a;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         gnt_b_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_b_q   <= gnt_b_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_b_d   = gnt_b_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_b_d  = last_b_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_a | req_b) begin
               state_d = ACCESS;
               cnt_d   = '0;
               gnt_b_d = pick_b;
               we_d    = pick_b ? we_b    : we_a;
               addr_d  = pick_b ? addr_b  : addr_a;
               wdata_d = pick_b ? wdata_b : wdata_a;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
               last_b_d = pick_b;
`endif
            end
         end
         ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               // Read data is sampled on the edge that closes the final access cycle.
               if (!we_q) begin
                  if (gnt_b_q) begin
                     rdata_b_d = sram_rdata;
                  end else begin
                     rdata_a_d = sram_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode the registered state, so an async reset clears them immediately.
   assign in_access  = (state_q == ACCESS);
   assign sram_read  = in_access & ~we_q;
   assign sram_write = in_access & we_q;
   assign sram_addr  = in_access ? addr_q  : '0;
   assign sram_wdata = in_access ? wdata_q : '0;
   assign done_a     = (state_q == DONE) & ~gnt_b_q;
   assign done_b     = (state_q == DONE) & gnt_b_q;
   assign rdata_a    = rdata_a_q;
   assign rdata_b    = rdata_b_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed transactions queue their expected completion,
// and independent monitors check done pulses, read data and SRAM-side protocol.
module tb_sram_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 128;
   localparam int AC     = 2;

   localparam logic [127:0] PRE10 = 128'h0010FFEF_0010FFEF_0010FFEF_0010FFEF;
   localparam logic [127:0] DEAD  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_a, req_b, we_a, we_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] wdata_a, wdata_b;
   logic              done_a, done_b;
   logic [DATA_W-1:0] rdata_a, rdata_b;
   logic              sram_read, sram_write;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      bit                is_b;
      bit                is_read;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .ACCESS_CYCLES(AC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_a(req_a),
      .req_b(req_b),
      .we_a(we_a),
      .we_b(we_b),
      .addr_a(addr_a),
      .addr_b(addr_b),
      .wdata_a(wdata_a),
      .wdata_b(wdata_b),
      .done_a(done_a),
      .done_b(done_b),
      .rdata_a(rdata_a),
      .rdata_b(rdata_b),
      .sram_read(sram_read),
      .sram_write(sram_write),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // SRAM model: unwritten words read back as {addr, ~addr} repeated.
   logic [DATA_W-1:0] mem [0:1023];
   bit                written [0:1023];

   always @(posedge clk) begin
      if (sram_write) begin
         mem[sram_addr[9:0]]     <= sram_wdata;
         written[sram_addr[9:0]] <= 1'b1;
      end
   end

   assign sram_rdata = written[sram_addr[9:0]] ? mem[sram_addr[9:0]] : {8{sram_addr, ~sram_addr}};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Completion monitor: every done pulse must match the oldest outstanding transaction.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (done_a || done_b)) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done_a=%b done_b=%b, required no done", done_a, done_b);
         end else begin
            e = q.pop_front();
            chk("done_who", {127'd0, done_b}, {127'd0, e.is_b});
            if (e.is_read) chk("rdata", e.is_b ? rdata_b : rdata_a, e.rdata);
         end
      end
   end

   // SRAM-side protocol monitor.
   int run = 0;
   always @(negedge clk) begin
      chk("rw_overlap", {127'd0, sram_read & sram_write}, 128'd0);
      chk("done_overlap", {127'd0, done_a & done_b}, 128'd0);
      if (!(sram_read || sram_write)) begin
         chk("idle_addr", {112'd0, sram_addr}, 128'd0);
         chk("idle_wdata", sram_wdata, 128'd0);
      end else if (q.size() > 0) begin
         chk("access_addr", {112'd0, sram_addr}, {112'd0, q[0].addr});
         chk("access_dir", {127'd0, sram_write}, {127'd0, !q[0].is_read});
         if (!q[0].is_read) chk("access_wdata", sram_wdata, q[0].wdata);
      end
      if (rst) begin
         run <= 0;
      end else if (sram_read || sram_write) begin
         run <= run + 1;
      end else if (run != 0) begin
         chk("access_len", 128'(run), 128'(AC));
         run <= 0;
      end
   end

   task automatic do_access(input bit is_b, input bit we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rd,
                            input bit drop_early);
      int k;
      int n;
      @(negedge clk);
      if (is_b) begin
         req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
      end else begin
         req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
      end
      q.push_back(exp_t'{is_b, !we, addr, wdata, exp_rd});
      @(posedge clk);
      #1;
      k = cyc;
      chk("grant_read_en", {127'd0, sram_read}, {127'd0, !we});
      chk("grant_write_en", {127'd0, sram_write}, {127'd0, we});
      if (drop_early) begin
         @(posedge clk);
         #1;
         req_a = 1'b0;
         req_b = 1'b0;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(done_a || done_b) && n < 20);
      chk("done_seen", {127'd0, done_a | done_b}, 128'd1);
      chk("done_latency", 128'(cyc - k + 1), 128'(AC + 1));
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   initial begin
      int n;
      int n_done;
      int last;
      bit b;
      rst = 1'b1;
      req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

      repeat (3) @(negedge clk);
      chk("rst_sram_read", {127'd0, sram_read}, 128'd0);
      chk("rst_sram_write", {127'd0, sram_write}, 128'd0);
      chk("rst_done_a", {127'd0, done_a}, 128'd0);
      chk("rst_done_b", {127'd0, done_b}, 128'd0);
      chk("rst_sram_addr", {112'd0, sram_addr}, 128'd0);
      chk("rst_sram_wdata", sram_wdata, 128'd0);
      chk("rst_rdata_a", rdata_a, 128'd0);
      chk("rst_rdata_b", rdata_b, 128'd0);
      rst = 1'b0;

      // A reads a preloaded word, B writes, A reads the written word back.
      do_access(1'b0, 1'b0, 16'h0010, '0, PRE10, 1'b0);
      do_access(1'b1, 1'b1, 16'h0200, DEAD, '0, 1'b0);
      do_access(1'b0, 1'b0, 16'h0200, '0, DEAD, 1'b0);

      // Reset clears read data and the arbitration pointer.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_rdata_a", rdata_a, 128'd0);
      rst = 1'b0;

      // Both requesters held for four grants.
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0010; wdata_a = '0;
      req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0200; wdata_b = '0;
      for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         b = (i % 2 == 1);
`else
         b = 1'b0;
`endif
         q.push_back(exp_t'{b, 1'b1, b ? 16'h0200 : 16'h0010, '0, b ? DEAD : PRE10});
      end
      last = 0;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(done_a || done_b) && n < 20);
         chk("contest_done_seen", {127'd0, done_a | done_b}, 128'd1);
         if (g > 0) chk("grant_period", 128'(cyc - last), 128'(AC + 2));
         last = cyc;
      end
      req_a = 1'b0;
      req_b = 1'b0;

      // Reset during the second access cycle aborts the access with no done.
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0030; wdata_a = '0;
      q.push_back(exp_t'{1'b0, 1'b1, 16'h0030, '0, '0});
      @(posedge clk);
      #1;
      chk("abort_acc1_read", {127'd0, sram_read}, 128'd1);
      @(posedge clk);
      #1;
      chk("abort_acc2_read", {127'd0, sram_read}, 128'd1);
      rst = 1'b1;
      req_a = 1'b0;
      q.delete();
      #1;
      chk("abort_read_drop", {127'd0, sram_read}, 128'd0);
      chk("abort_write_drop", {127'd0, sram_write}, 128'd0);
      chk("abort_addr_drop", {112'd0, sram_addr}, 128'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done_a || done_b) n_done++;
      end
      chk("abort_no_done", 128'(n_done), 128'd0);

      // Normal operation after the aborted access.
      do_access(1'b1, 1'b0, 16'h0200, '0, DEAD, 1'b0);

      // A drops req one cycle after its grant; the access still completes once.
      do_access(1'b0, 1'b0, 16'h0010, '0, PRE10, 1'b1);
      n_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done_a || done_b) n_done++;
      end
      chk("early_drop_single_done", 128'(n_done), 128'd0);
      chk("scoreboard_empty", 128'(q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: address width in bits, shared by requesters and SRAM.
REQ-002 Parameter DATA_W, default 128: data width in bits (16 one-byte words).
REQ-003 Parameter ACCESS_CYCLES, default 2: cycles the SRAM enable is held per access; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_a / req_b  input  1  request from requester A / B, held until its done pulse.
REQ-007 we_a / we_b  input  1  operation select: 1 = write, 0 = read; stable while the request is held.
REQ-008 addr_a / addr_b  input  ADDR_W  access address; stable while the request is held.
REQ-009 wdata_a / wdata_b  input  DATA_W  write data; stable while the request is held.
REQ-010 done_a / done_b  output  1  one-cycle completion pulse for A / B.
REQ-011 rdata_a / rdata_b  output  DATA_W  registered read data; valid in the done cycle of a read and held until the next read by the same requester.
REQ-012 sram_read / sram_write  output  1  SRAM read / write enables.
REQ-013 sram_addr  output  ADDR_W  SRAM address.
REQ-014 sram_wdata  output  DATA_W  SRAM write data.
REQ-015 sram_rdata  input  DATA_W  SRAM read data.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE: if any req is high, register the grant, the granted requester's we/addr/wdata and a cycle counter of 0, then go to ACCESS; otherwise stay in IDLE.
REQ-018 ACCESS: assert exactly one of sram_read / sram_write, per the registered we, for exactly ACCESS_CYCLES consecutive cycles with sram_addr and sram_wdata held constant; after that go to DONE.
REQ-019 Never assert sram_read and sram_write in the same cycle; both are 0 outside ACCESS.
REQ-020 On a read, capture sram_rdata into the granted requester's rdata register on the last ACCESS cycle's clock edge.
REQ-021 DONE: pulse the granted requester's done for one cycle, then return to IDLE; no new grant is issued in DONE.
REQ-022 Latency: a request sampled in IDLE at edge k gives ACCESS cycles k+1..k+ACCESS_CYCLES and done in cycle k+ACCESS_CYCLES+1.
REQ-023 Back-to-back: minimum period between grants is ACCESS_CYCLES+2 cycles.
REQ-024 A req deasserted mid-access does not abort the access; done still pulses.
REQ-025 A requester holding req high through its own done cycle is treated as a new request in the following IDLE.
REQ-026 sram_addr and sram_wdata are 0 in IDLE.
REQ-027 done_a and done_b are never both high in the same cycle.

Reset
REQ-028 rst high asynchronously forces state to IDLE and clears the counter.
REQ-029 rst high asynchronously drives sram_read, sram_write, done_a and done_b to 0, and sram_addr, sram_wdata, rdata_a and rdata_b to 0.
REQ-030 Round-robin pointer resets to favour A.
REQ-031 Reset asserted mid-access terminates the access immediately; no done pulse follows.

Configuration
REQ-032 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not served last; the pointer updates on each grant.
REQ-033 Macro SRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, with A always winning simultaneous requests; no pointer state is built.

Verification
REQ-034 Reset, then A reads 0x0010 with ACCESS_CYCLES=2 -> sram_read high for 2 cycles, addr 0x0010; done_a 3 cycles after the grant edge; rdata_a equals the preloaded SRAM word.
REQ-035 B writes 0xDEADBEEF... to 0x0200, then A reads 0x0200 -> rdata_a equals the written 128-bit value, and sram_write and sram_read are never overlapped.
REQ-036 req_a and req_b held high for 4 grants, round-robin build -> grant order A,B,A,B; fixed-priority build -> A,A,A,A.
REQ-037 rst pulsed during the 2nd ACCESS cycle -> enables drop in the same cycle, no done pulse, state IDLE; the next request completes normally.
REQ-038 A drops req one cycle after the grant -> access completes and done_a pulses once.
